ytile_row_writer: RTL and testbench

//   Store-side counterpart of the X-tile row loader. Captures one parallel row of
//   N result words for row index k, then streams it into the Y SRAM write port as
//   N single-word beats, n = 0..N-1. Completion uses the same level-valid/accept

---
 rtl/ytile_row_writer.sv | 114 +++++++++++
 tb/tb_ytile_row_writer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ytile_row_writer.sv
// Y-tile row writer: captures one N-word result row for row k and streams it
// into the Y SRAM write port one word per granted beat, then holds row_done
// until the consumer accepts.
module ytile_row_writer #(
  parameter int unsigned N      = 8,
  parameter int unsigned KMAX   = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYTE_W = 4,
  parameter int unsigned N_W    = (N <= 1) ? 1 : $clog2(N),
  parameter int unsigned K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_k,
  input  logic [K_W-1:0]      k_idx,
  input  logic [N*DATA_W-1:0] row_data,
  output logic                busy,
  output logic                row_done,
  input  logic                row_accept,
  output logic                start_dropped,
  input  logic                sram_gnt,
  output logic                y_en,
  output logic                y_we,
  output logic [K_W-1:0]      y_k,
  output logic [N_W-1:0]      y_n,
  output logic [DATA_W-1:0]   y_wdata,
  output logic [BYTE_W-1:0]   y_wmask
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_W-1:0]      n_cnt_q, n_cnt_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [N*DATA_W-1:0] buf_q, buf_d;
  logic                drop_q, drop_d;

  // State, counter, row buffer and sticky drop flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_cnt_q <= '0;
      k_q     <= '0;
      buf_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_cnt_q <= n_cnt_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state: latch on start, advance one column per grant, wait for accept.
  always_comb begin
    state_d = state_q;
    n_cnt_d = n_cnt_q;
    k_d     = k_q;
    buf_d   = buf_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle: begin
        if (start_k) begin
          k_d     = k_idx;
          buf_d   = row_data;
          n_cnt_d = '0;
          drop_d  = 1'b0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (start_k) drop_d = 1'b1;
        if (sram_gnt) begin
          if (n_cnt_q == N_W'(N - 1)) begin
            n_cnt_d = '0;
            state_d = StDone;
          end else begin
            n_cnt_d = n_cnt_q + N_W'(1);
          end
        end
      end
      StDone: begin
        // A start alongside the accept is still dropped: state is not yet idle.
        if (start_k) drop_d = 1'b1;
        if (row_accept) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; no input-to-output path.
  always_comb begin
    y_en    = 1'b0;
    y_we    = 1'b0;
    y_k     = '0;
    y_n     = '0;
    y_wdata = '0;
    y_wmask = '0;
    if (state_q == StWrite) begin
      y_en    = 1'b1;
      y_we    = 1'b1;
      y_k     = k_q;
      y_n     = n_cnt_q;
      y_wdata = buf_q[n_cnt_q * DATA_W +: DATA_W];
      y_wmask = {BYTE_W{1'b1}};
    end
  end

  assign busy          = (state_q != StIdle);
  assign row_done      = (state_q == StDone);
  assign start_dropped = drop_q;

endmodule

// File: tb/tb_ytile_row_writer.sv
// Bench for ytile_row_writer: directed rows, expected beats queued at stimulus
// time and popped by an independent monitor that also models the Y SRAM.
module tb_ytile_row_writer;

  logic         clk;
  logic         rst_n;
  logic         start_k;
  logic [9:0]   k_idx;
  logic [255:0] row_data;
  logic         busy;
  logic         row_done;
  logic         row_accept;
  logic         start_dropped;
  logic         sram_gnt;
  logic         y_en;
  logic         y_we;
  logic [9:0]   y_k;
  logic [2:0]   y_n;
  logic [31:0]  y_wdata;
  logic [3:0]   y_wmask;

  ytile_row_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_k       (start_k),
    .k_idx         (k_idx),
    .row_data      (row_data),
    .busy          (busy),
    .row_done      (row_done),
    .row_accept    (row_accept),
    .start_dropped (start_dropped),
    .sram_gnt      (sram_gnt),
    .y_en          (y_en),
    .y_we          (y_we),
    .y_k           (y_k),
    .y_n           (y_n),
    .y_wdata       (y_wdata),
    .y_wmask       (y_wmask)
  );

  typedef struct packed {
    logic [9:0]  k;
    logic [2:0]  n;
    logic [31:0] d;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem[int];
  bit          written[int];
  int          n_checks;
  int          n_fail;
  int          row_writes;
  int          cyc;
  logic [3:0]  gpat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] v(input int k, input int n);
    return 32'hC000_0000 + 32'(k << 16) + 32'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_row(input int k);
    int c = 0;
    foreach (written[key]) if (key / 8 == k) c++;
    return c;
  endfunction

  task automatic check_zero(input string name);
    check(name, 64'({busy, row_done, start_dropped, y_en, y_we, y_k, y_n, y_wdata, y_wmask}),
          64'(0));
  endtask

  // Drive a start for row k; queue the first nexp beats the SRAM should see.
  task automatic start_row(input int k, input int nexp);
    logic [255:0] rd;
    beat_t        b;
    for (int n = 0; n < 8; n++) begin
      rd[n*32 +: 32] = v(k, n);
      if (n < nexp) begin
        b.k = k[9:0];
        b.n = 3'(n);
        b.d = v(k, n);
        exp_q.push_back(b);
      end
    end
    row_writes = 0;
    k_idx      = k[9:0];
    row_data   = rd;
    start_k    = 1'b1;
    step();
    start_k  = 1'b0;
    k_idx    = 10'($urandom);
    row_data = {8{$urandom}};
  endtask

  // Run grants until row_done (bounded); cycles = loop index where it was seen.
  task automatic wait_done(input bit toggle, output int cycles);
    cycles = -1;
    for (int i = 0; i < 100; i++) begin
      sram_gnt = toggle ? gpat[i % 4] : 1'b1;
      @(negedge clk);
      if (row_done) begin
        cycles = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("row_done_seen", 64'(row_done), 64'(1));
    check("writes_before_done", 64'(row_writes), 64'(8));
    sram_gnt = 1'b1;
  endtask

  task automatic accept(input bit with_start);
    step();
    check("row_done_held", 64'(row_done), 64'(1));
    row_accept = 1'b1;
    start_k    = with_start;
    step();
    row_accept = 1'b0;
    start_k    = 1'b0;
    @(negedge clk);
    check("idle_after_accept", 64'({busy, row_done}), 64'(0));
  endtask

  // Monitor: scoreboard pop on each granted beat, stall stability, SRAM model.
  initial begin
    logic [49:0] vec, prev_vec;
    bit          prev_stall;
    beat_t       e;
    int          key;
    prev_stall = 1'b0;
    prev_vec   = '0;
    forever begin
      @(negedge clk);
      vec = {y_we, y_wmask, y_k, y_n, y_wdata};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", 64'(vec), 64'(prev_vec));
        if (y_en && sram_gnt) begin
          key = int'(y_k) * 8 + int'(y_n);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got k=%0d n=%0d, expected no beat", y_k, y_n);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(vec), 64'({1'b1, 4'hF, e.k, e.n, e.d}));
          end
          if (written.exists(key)) begin
            n_checks++;
            n_fail++;
            $display("FAIL duplicate_write: got second write k=%0d n=%0d, expected one", y_k, y_n);
          end
          written[key] = 1'b1;
          mem[key]     = y_wdata;
          row_writes++;
        end
        prev_stall = y_en && !sram_gnt;
        prev_vec   = vec;
      end
    end
  end

  initial begin
    int klist[3];
    int c;
    n_checks   = 0;
    n_fail     = 0;
    row_writes = 0;
    gpat       = 4'b1001;
    rst_n      = 1'b0;
    start_k    = 1'b0;
    k_idx      = '0;
    row_data   = '0;
    row_accept = 1'b0;
    sram_gnt   = 1'b1;
    #12;
    check_zero("reset_outputs");
    step();
    rst_n = 1'b1;
    step();

    // 1: single row, gnt tied high, exact latency
    start_row(0, 8);
    check("busy_after_start", 64'(busy), 64'(1));
    wait_done(1'b0, cyc);
    check("t1_done_latency", 64'(cyc), 64'(8));
    accept(1'b0);

    // 2: back-to-back rows with row_data changed after the start edge
    written.delete();
    mem.delete();
    klist = '{7, 3, 9};
    foreach (klist[i]) begin
      start_row(klist[i], 8);
      wait_done(1'b0, cyc);
      accept(1'b0);
    end
    foreach (klist[i])
      for (int n = 0; n < 8; n++) begin
        c = klist[i] * 8 + n;
        check("t2_sram_word", mem.exists(c) ? 64'(mem[c]) : 64'hDEAD, 64'(v(klist[i], n)));
      end
    c = count_row(0) + count_row(1) + count_row(2) + count_row(4) + count_row(5)
      + count_row(6) + count_row(8);
    check("t2_untouched_rows", 64'(c), 64'(0));

    // 3: grant pattern 1,0,0,1 with stalls
    start_row(5, 8);
    wait_done(1'b1, cyc);
    check("t3_done_latency", 64'(cyc), 64'(16));
    check("t3_row_count", 64'(count_row(5)), 64'(8));
    accept(1'b0);

    // 4: starts during WRITE and alongside accept are dropped
    check("t4_drop_clear_before", 64'(start_dropped), 64'(0));
    start_row(6, 8);
    start_k = 1'b1;
    step();
    start_k = 1'b0;
    @(negedge clk);
    check("t4_drop_in_write", 64'(start_dropped), 64'(1));
    wait_done(1'b0, cyc);
    accept(1'b1);
    check("t4_drop_after_accept", 64'(start_dropped), 64'(1));
    step();
    step();
    check("t4_no_extra_row", 64'({busy, y_en}), 64'(0));
    start_row(8, 8);
    check("t4_drop_cleared", 64'(start_dropped), 64'(0));
    wait_done(1'b0, cyc);
    accept(1'b0);

    // 5: reset during beat 3 of row 2
    start_row(2, 3);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_zero("t5_reset_mid_row");
    step();
    rst_n = 1'b1;
    step();
    check_zero("t5_after_release");
    check("t5_partial_row", 64'(count_row(2)), 64'(3));
    start_row(4, 8);
    wait_done(1'b0, cyc);
    accept(1'b0);

    // 6: stray accepts and the top row address
    row_accept = 1'b1;
    step();
    row_accept = 1'b0;
    @(negedge clk);
    check_zero("t6_idle_accept");
    start_row(1023, 8);
    row_accept = 1'b1;
    step();
    row_accept = 1'b0;
    wait_done(1'b0, cyc);
    check("t6_done_latency", 64'(cyc), 64'(7));
    check("t6_row_count", 64'(count_row(1023)), 64'(8));
    accept(1'b0);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
